// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared helpers and write-side opcode
// encoding for the 2-read/1-write register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WRITE,
    OP_CLEAR,
    OP_PRESET
  } bank_op_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic logic [31:0] all_ones(input int bits);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++)
      if (i < bits) v[i] = 1'b1;
    return v;
  endfunction

  // Preset beats clear beats write.
  function automatic bank_op_e encode_op(
    input logic preset,
    input logic clr,
    input logic wr
  );
    bank_op_e op;
    priority case (1'b1)
      preset:  op = OP_PRESET;
      clr:     op = OP_CLEAR;
      wr:      op = OP_WRITE;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// reg_bank_read_port: one registered read port with
// write bypass, register-0 masking and range check.
module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int NrOfBits   = 8,
  parameter int NrOfRegs   = 8,
  parameter int AddrBits   = 3,
  parameter int ReadBypass = 1,
  parameter int Reg0Zero   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                rd_en,
  input  logic [AddrBits-1:0] rd_addr,
  input  logic [NrOfRegs-1:0][NrOfBits-1:0] regs,
  input  bank_op_e            op,
  input  logic [AddrBits-1:0] wr_addr,
  input  logic [NrOfBits-1:0] wr_data,
  output logic [NrOfBits-1:0] rd_data,
  output logic                rd_valid,
  output logic                range_err
);

  localparam bit Sparse =
    NrOfRegs != (1 << clog2(NrOfRegs));
  localparam logic [NrOfBits-1:0] Ones =
    NrOfBits'(all_ones(NrOfBits));

  logic                in_range;
  logic [NrOfBits-1:0] word;

  assign in_range =
    !Sparse || (int'(rd_addr) < NrOfRegs);
  assign range_err = rd_en && !in_range;

  always_comb begin
    word = '0;
    for (int i = 0; i < NrOfRegs; i++)
      if (rd_addr == AddrBits'(i)) word = regs[i];
    if (ReadBypass != 0) begin
      unique case (op)
        OP_PRESET: word = Ones;
        OP_CLEAR:
          if (wr_addr == rd_addr) word = '0;
        OP_WRITE:
          if (wr_addr == rd_addr) word = wr_data;
        default: ;
      endcase
    end
    // Masking runs last so bypass cannot leak through.
    if (!in_range ||
        (Reg0Zero != 0 && rd_addr == '0))
      word = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (en) begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= word;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_bank_2r1w.sv
// reg_bank_2r1w: parametrised register bank with one
// write port and two registered read ports.
module reg_bank_2r1w
  import reg_bank_pkg::*;
#(
  parameter int NrOfBits    = 8,
  parameter int NrOfRegs    = 8,
  parameter int AddrBits    = 3,
  parameter int ActiveLevel = 1,
  parameter int ReadBypass  = 1,
  parameter int Reg0Zero    = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                Preset,
  input  logic                ClrAddrEn,
  input  logic                WrEn,
  input  logic [AddrBits-1:0] WrAddr,
  input  logic [NrOfBits-1:0] WrData,
  input  logic                RdEn0,
  input  logic [AddrBits-1:0] RdAddr0,
  input  logic                RdEn1,
  input  logic [AddrBits-1:0] RdAddr1,
  input  logic                cs,
  output logic [NrOfBits-1:0] RdData0,
  output logic [NrOfBits-1:0] RdData1,
  output logic                RdValid0,
  output logic                RdValid1,
  output logic                AddrErr
);

  localparam bit Sparse =
    NrOfRegs != (1 << clog2(NrOfRegs));
  localparam logic [NrOfBits-1:0] Ones =
    NrOfBits'(all_ones(NrOfBits));

  logic                clk_act;
  logic                en;
  logic                wr_ok;
  logic                err0;
  logic                err1;
  bank_op_e            op;
  logic [NrOfBits-1:0] data0;
  logic [NrOfBits-1:0] data1;
  logic [NrOfRegs-1:0][NrOfBits-1:0] regs;

  // Falling-edge builds invert the clock once here.
  assign clk_act = (ActiveLevel != 0) ? Clock : ~Clock;
  assign en      = ClockEnable & Tick;
  assign op      = encode_op(Preset, ClrAddrEn, WrEn);
  assign wr_ok   =
    !Sparse || (int'(WrAddr) < NrOfRegs);

  always_ff @(posedge clk_act) begin
    if (Reset) begin
      regs    <= '0;
      AddrErr <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        if (Reg0Zero == 0 || i != 0) begin
          unique case (op)
            OP_PRESET: regs[i] <= Ones;
            OP_CLEAR:
              if (WrAddr == AddrBits'(i))
                regs[i] <= '0;
            OP_WRITE:
              if (WrAddr == AddrBits'(i))
                regs[i] <= WrData;
            default: ;
          endcase
        end
      end
      if (err0 || err1 ||
          ((WrEn || ClrAddrEn) && !wr_ok))
        AddrErr <= 1'b1;
    end
  end

  reg_bank_read_port #(
    .NrOfBits  (NrOfBits),
    .NrOfRegs  (NrOfRegs),
    .AddrBits  (AddrBits),
    .ReadBypass(ReadBypass),
    .Reg0Zero  (Reg0Zero)
  ) u_rd0 (
    .clk      (clk_act),
    .reset    (Reset),
    .en       (en),
    .rd_en    (RdEn0),
    .rd_addr  (RdAddr0),
    .regs     (regs),
    .op       (op),
    .wr_addr  (WrAddr),
    .wr_data  (WrData),
    .rd_data  (data0),
    .rd_valid (RdValid0),
    .range_err(err0)
  );

  reg_bank_read_port #(
    .NrOfBits  (NrOfBits),
    .NrOfRegs  (NrOfRegs),
    .AddrBits  (AddrBits),
    .ReadBypass(ReadBypass),
    .Reg0Zero  (Reg0Zero)
  ) u_rd1 (
    .clk      (clk_act),
    .reset    (Reset),
    .en       (en),
    .rd_en    (RdEn1),
    .rd_addr  (RdAddr1),
    .regs     (regs),
    .op       (op),
    .wr_addr  (WrAddr),
    .wr_data  (WrData),
    .rd_data  (data1),
    .rd_valid (RdValid1),
    .range_err(err1)
  );

  assign RdData0 = cs ? '0 : data0;
  assign RdData1 = cs ? '0 : data1;

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// tb_reg_bank_2r1w: two bank configurations driven in
// lockstep, checked by vectors, sequences and a model.
module tb_reg_bank_2r1w;

  typedef struct {
    int rst; int ce; int tk; int pre; int clr;
    int we; int wa; int wd;
    int re0; int ra0; int re1; int ra1; int c;
    int d0; int v0; int d1; int v1; int err;
  } vec_t;

  logic       Clock;
  logic       Reset, ClockEnable, Tick, Preset;
  logic       ClrAddrEn, WrEn, RdEn0, RdEn1, cs;
  logic [2:0] WrAddr, RdAddr0, RdAddr1;
  logic [7:0] WrData;
  logic [7:0] a_d0, a_d1, b_d0, b_d1;
  logic       a_v0, a_v1, a_err, b_v0, b_v1, b_err;

  int checks;
  int failures;

  // Model state: index 0 = default bank, 1 = small bank.
  int nregs[2] = '{8, 6};
  int byp[2]   = '{1, 0};
  int r0z[2]   = '{0, 1};
  int mem[2][8];
  int rd[2][2];
  int vld[2][2];
  int err[2];

  vec_t vecs[17];

  reg_bank_2r1w u_a (
    .Clock(Clock), .Reset(Reset),
    .ClockEnable(ClockEnable), .Tick(Tick),
    .Preset(Preset), .ClrAddrEn(ClrAddrEn),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn0(RdEn0), .RdAddr0(RdAddr0),
    .RdEn1(RdEn1), .RdAddr1(RdAddr1), .cs(cs),
    .RdData0(a_d0), .RdData1(a_d1),
    .RdValid0(a_v0), .RdValid1(a_v1),
    .AddrErr(a_err)
  );

  reg_bank_2r1w #(
    .NrOfBits(8), .NrOfRegs(6), .AddrBits(3),
    .ActiveLevel(0), .ReadBypass(0), .Reg0Zero(1)
  ) u_b (
    .Clock(Clock), .Reset(Reset),
    .ClockEnable(ClockEnable), .Tick(Tick),
    .Preset(Preset), .ClrAddrEn(ClrAddrEn),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .RdEn0(RdEn0), .RdAddr0(RdAddr0),
    .RdEn1(RdEn1), .RdAddr1(RdAddr1), .cs(cs),
    .RdData0(b_d0), .RdData1(b_d1),
    .RdValid0(b_v0), .RdValid1(b_v1),
    .AddrErr(b_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input int rst, input int ce, input int tk,
    input int pre, input int clr, input int we,
    input int wa, input int wd,
    input int re0, input int ra0,
    input int re1, input int ra1, input int c);
    Reset       = (rst != 0);
    ClockEnable = (ce != 0);
    Tick        = (tk != 0);
    Preset      = (pre != 0);
    ClrAddrEn   = (clr != 0);
    WrEn        = (we != 0);
    WrAddr      = 3'(wa);
    WrData      = 8'(wd);
    RdEn0       = (re0 != 0);
    RdAddr0     = 3'(ra0);
    RdEn1       = (re1 != 0);
    RdAddr1     = 3'(ra1);
    cs          = (c != 0);
  endtask

  // Spec-level reference: reads see pre-edge contents,
  // optionally overridden by what this edge writes.
  task automatic model_update();
    int wa, wd, v;
    int ra[2];
    int re[2];
    wa = int'(WrAddr);
    wd = int'(WrData);
    ra[0] = int'(RdAddr0);
    ra[1] = int'(RdAddr1);
    re[0] = RdEn0 ? 1 : 0;
    re[1] = RdEn1 ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (Reset) begin
        for (int i = 0; i < 8; i++) mem[k][i] = 0;
        for (int p = 0; p < 2; p++) begin
          rd[k][p] = 0;
          vld[k][p] = 0;
        end
        err[k] = 0;
      end else if (ClockEnable && Tick) begin
        for (int p = 0; p < 2; p++) begin
          if (re[p] != 0) begin
            v = (ra[p] < nregs[k]) ? mem[k][ra[p]] : 0;
            if (byp[k] != 0) begin
              if (Preset) v = 255;
              else if (ClrAddrEn && wa == ra[p]) v = 0;
              else if (WrEn && wa == ra[p]) v = wd;
            end
            if (ra[p] >= nregs[k]) begin
              v = 0;
              err[k] = 1;
            end
            if (r0z[k] != 0 && ra[p] == 0) v = 0;
            rd[k][p] = v;
            vld[k][p] = 1;
          end else begin
            vld[k][p] = 0;
          end
        end
        if ((WrEn || ClrAddrEn) && wa >= nregs[k])
          err[k] = 1;
        if (Preset) begin
          for (int i = 0; i < nregs[k]; i++)
            if (r0z[k] == 0 || i != 0) mem[k][i] = 255;
        end else if (wa < nregs[k] &&
                     (r0z[k] == 0 || wa != 0)) begin
          if (ClrAddrEn) mem[k][wa] = 0;
          else if (WrEn) mem[k][wa] = wd;
        end
      end else begin
        vld[k][0] = 0;
        vld[k][1] = 0;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    int ad[2][2];
    int av[2][2];
    int ae[2];
    ad[0][0] = int'(a_d0); ad[0][1] = int'(a_d1);
    ad[1][0] = int'(b_d0); ad[1][1] = int'(b_d1);
    av[0][0] = int'(a_v0); av[0][1] = int'(a_v1);
    av[1][0] = int'(b_v0); av[1][1] = int'(b_v1);
    ae[0] = int'(a_err);
    ae[1] = int'(b_err);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s_m%0d_d%0d", tag, k, p),
              ad[k][p], cs ? 0 : rd[k][p]);
        check($sformatf("%s_m%0d_v%0d", tag, k, p),
              av[k][p], vld[k][p]);
      end
      check($sformatf("%s_m%0d_err", tag, k),
            ae[k], err[k]);
    end
  endtask

  task automatic apply(input string tag);
    model_update();
    @(posedge Clock);
    #1;
    compare_model(tag);
  endtask

  task automatic idle();
    drive(0,1,1,0,0,0,0,0,0,0,0,0,0);
  endtask

  function automatic int one_in(input int n);
    return ($urandom_range(0, n - 1) == 0) ? 1 : 0;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    // rst ce tk pre clr we wa wd re0 ra0 re1 ra1 cs
    //   | d0 v0 d1 v1 err   (default bank)
    vecs[0]  = '{1,0,0,0,0,0,0,0,   0,0,0,0,0,
                 0,0,0,0,0};
    vecs[1]  = '{0,1,1,0,0,1,3,'hA5,0,0,0,0,0,
                 0,0,0,0,0};
    vecs[2]  = '{0,1,1,0,0,0,0,0,   1,3,0,0,0,
                 'hA5,1,0,0,0};
    vecs[3]  = '{0,1,1,0,0,0,0,0,   0,0,0,0,0,
                 'hA5,0,0,0,0};
    vecs[4]  = '{0,1,1,0,0,1,5,'h11,0,0,0,0,0,
                 'hA5,0,0,0,0};
    vecs[5]  = '{0,1,1,0,0,1,5,'h3C,0,0,1,5,0,
                 'hA5,0,'h3C,1,0};
    vecs[6]  = '{0,1,1,1,0,0,0,0,   0,0,0,0,0,
                 'hA5,0,'h3C,0,0};
    vecs[7]  = '{0,1,1,0,1,1,2,'h77,1,2,1,4,0,
                 0,1,'hFF,1,0};
    vecs[8]  = '{0,1,1,0,0,0,0,0,   1,2,0,0,0,
                 0,1,'hFF,0,0};
    vecs[9]  = '{0,1,0,0,0,1,1,'h42,1,1,1,1,0,
                 0,0,'hFF,0,0};
    vecs[10] = '{0,1,1,0,0,0,0,0,   1,1,0,0,0,
                 'hFF,1,'hFF,0,0};
    vecs[11] = '{0,1,1,0,0,1,1,'h42,0,0,0,0,0,
                 'hFF,0,'hFF,0,0};
    vecs[12] = '{0,1,1,0,0,0,0,0,   1,1,1,1,0,
                 'h42,1,'h42,1,0};
    vecs[13] = '{0,1,1,0,0,0,0,0,   1,3,1,3,1,
                 0,1,0,1,0};
    vecs[14] = '{0,0,1,0,0,0,0,0,   1,4,0,0,0,
                 'hFF,0,'hFF,0,0};
    vecs[15] = '{1,1,1,0,0,1,1,'h99,1,1,0,0,0,
                 0,0,0,0,0};
    vecs[16] = '{0,1,1,0,0,0,0,0,   1,1,1,3,0,
                 0,1,0,1,0};

    drive(1,0,0,0,0,0,0,0,0,0,0,0,0);
    @(posedge Clock);
    #1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].ce, vecs[i].tk,
            vecs[i].pre, vecs[i].clr, vecs[i].we,
            vecs[i].wa, vecs[i].wd,
            vecs[i].re0, vecs[i].ra0,
            vecs[i].re1, vecs[i].ra1, vecs[i].c);
      apply("vec");
      check($sformatf("vec%0d_d0", i),
            int'(a_d0), vecs[i].d0);
      check($sformatf("vec%0d_v0", i),
            int'(a_v0), vecs[i].v0);
      check($sformatf("vec%0d_d1", i),
            int'(a_d1), vecs[i].d1);
      check($sformatf("vec%0d_v1", i),
            int'(a_v1), vecs[i].v1);
      check($sformatf("vec%0d_err", i),
            int'(a_err), vecs[i].err);
    end

    // Same-edge write and read: bypass vs old contents.
    drive(1,0,0,0,0,0,0,0,0,0,0,0,0); apply("byp");
    drive(0,1,1,0,0,1,5,'h11,0,0,0,0,0); apply("byp");
    drive(0,1,1,0,0,1,5,'h3C,0,0,1,5,0); apply("byp");
    check("byp_a_d1", int'(a_d1), 'h3C);
    check("byp_b_d1", int'(b_d1), 'h11);
    drive(0,1,1,0,0,0,0,0,0,0,1,5,0); apply("byp");
    check("byp_b_d1_next", int'(b_d1), 'h3C);

    // Out-of-range access on the six-entry bank.
    drive(1,0,0,0,0,0,0,0,0,0,0,0,0); apply("rng");
    drive(0,1,1,0,0,1,7,'h5A,1,6,1,6,0); apply("rng");
    check("rng_b_d0", int'(b_d0), 0);
    check("rng_b_v0", int'(b_v0), 1);
    check("rng_b_v1", int'(b_v1), 1);
    check("rng_b_err", int'(b_err), 1);
    check("rng_a_err", int'(a_err), 0);
    drive(0,1,1,0,0,0,0,0,1,7,1,7,1); apply("rng");
    check("rng_cs_a_d0", int'(a_d0), 0);
    check("rng_cs_a_v0", int'(a_v0), 1);
    check("rng_cs_b_v1", int'(b_v1), 1);
    idle(); apply("rng");
    check("rng_a_d0", int'(a_d0), 'h5A);
    check("rng_b_err_sticky", int'(b_err), 1);
    drive(1,0,0,0,0,0,0,0,0,0,0,0,0); apply("rng");
    check("rng_b_err_clr", int'(b_err), 0);

    // Register 0 masking, edge choice, reset vs write.
    idle(); apply("r0");
    drive(0,1,1,0,0,1,0,'hFF,0,0,0,0,0); apply("r0");
    drive(0,1,1,0,0,0,0,0,1,0,0,0,0);
    @(negedge Clock);
    #1;
    check("edge_b_v0", int'(b_v0), 1);
    check("edge_a_v0", int'(a_v0), 0);
    apply("r0");
    check("r0_a_d0", int'(a_d0), 'hFF);
    check("r0_b_d0", int'(b_d0), 0);
    drive(1,1,1,0,0,1,1,'h99,1,1,0,0,0); apply("r0");
    check("r0_rst_v0", int'(a_v0), 0);
    drive(0,1,1,0,0,0,0,0,1,1,1,1,0); apply("r0");
    check("r0_a_d0_after", int'(a_d0), 0);
    check("r0_b_d1_after", int'(b_d1), 0);
    check("r0_a_v0_after", int'(a_v0), 1);

    for (int n = 0; n < 400; n++) begin
      drive(one_in(32),
            1 - one_in(8), 1 - one_in(8),
            one_in(16), one_in(8),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)),
            one_in(4));
      apply("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_2r1w.md
Name: reg_bank_2r1w

Overview:
- Parametrised successor to the single flip-flop register used in the CPU memory path.
- Holds NrOfRegs words of NrOfBits each, with one write port and two registered read ports.
- Supports synchronous preset/clear, Tick/ClockEnable write gating and write-to-read bypass.
- Feeds the CPU datapath operand buses. A disable input forces the read outputs to zero; no tristates are used.

Parameters:
- NrOfBits, 8, word width (1..32).
- NrOfRegs, 8, number of registers (2..32).
- AddrBits, 3, address width; must equal ceil(log2(NrOfRegs)).
- ActiveLevel, 1, capture edge: 1 = rising edge of Clock, 0 = falling edge. All state, including reset, uses this edge.
- ReadBypass, 1, 1 = a read of the address being written in the same cycle returns WrData; 0 = it returns the old contents.
- Reg0Zero, 0, 1 = register 0 reads as zero and ignores writes.

Ports:
- Clock  in  1  single clock.
- Reset  in  1  synchronous, active-high; clears all state.
- ClockEnable  in  1  global enable; qualifies writes, reads, preset and clear.
- Tick  in  1  clock-divider tick; ANDed with ClockEnable to form en.
- Preset  in  1  synchronous; sets every register to all-ones.
- ClrAddrEn  in  1  synchronous clear of the register at WrAddr.
- WrEn  in  1  write request.
- WrAddr  in  AddrBits  write address.
- WrData  in  NrOfBits  write data.
- RdEn0 / RdEn1  in  1  read requests.
- RdAddr0 / RdAddr1  in  AddrBits  read addresses.
- cs  in  1  output disable; 1 forces RdData0/RdData1 to 0.
- RdData0 / RdData1  out  NrOfBits  registered read data.
- RdValid0 / RdValid1  out  1  high for one active edge after an accepted read.
- AddrErr  out  1  sticky; set on any access with an address >= NrOfRegs.

Behaviour:
- en = ClockEnable & Tick. All events below occur on the active edge only when en=1. The exception is Reset, which acts on the active edge regardless of en.
- Reset: all registers = 0, RdData* internal registers = 0, RdValid* = 0, AddrErr = 0. Reset has priority over everything.
- Priority per register, highest first: Reset > Preset > ClrAddrEn (target = WrAddr) > WrEn.
  - Preset sets all registers to all-ones.
  - ClrAddrEn and WrEn together: the clear wins and the write is dropped.
- Write: with WrEn=1 and WrAddr < NrOfRegs, regs[WrAddr] <= WrData on the same edge.
- Read latency is 1 edge. With RdEnN=1, RdDataN <= regs[RdAddrN] and RdValidN <= 1.
  - With RdEnN=0, RdDataN holds its value and RdValidN <= 0.
  - With en=0, all state holds; RdValid* <= 0.
- Bypass (ReadBypass=1): a same-edge read of the address being written returns WrData.
  - If ClrAddrEn targets the read address, the read returns 0.
  - If Preset is active, the read returns all-ones.
  - With ReadBypass=0, the read returns the pre-edge contents.
- Reg0Zero=1: writes, clears and presets to address 0 are ignored, and reads of address 0 return 0 (bypass included).
- Out-of-range address (possible when NrOfRegs < 2^AddrBits):
  - Out-of-range write is ignored.
  - Out-of-range read returns 0 with RdValid=1.
  - AddrErr <= 1 and stays set until Reset.
- Both read ports may address the same register; the results are independent and identical.
- cs is combinational, masks data only, and does not affect RdValid* or internal state.
- ActiveLevel=0: identical behaviour on the falling edge. Only one edge process exists; there are no dual-edge registers.
- Reset asserted mid-sequence: any write or read on that edge is discarded. Outputs read 0 and valid flags are 0 on the following cycle.

Decomposition:
- Shared package reg_bank_pkg holds the clog2 function, an all-ones constant generator and the priority encoding of the clear/preset/write opcodes.
- One natural sub-module: reg_bank_read_port, which handles registered read, bypass mux, Reg0Zero masking and range check. It is instantiated twice.

Test Plan:
- NrOfBits=8, NrOfRegs=8: Reset then write 0xA5 to addr 3, then RdEn0 on addr 3 -> RdData0=0xA5 and RdValid0=1 one edge later. RdValid0=0 on the following edge if RdEn0 drops.
- Same-edge WrEn addr 5 = 0x3C and RdEn1 addr 5 (previously 0x11) -> RdData1=0x3C with ReadBypass=1, and 0x11 with ReadBypass=0.
- Preset, then ClrAddrEn addr 2 with WrEn addr 2 = 0x77 -> read addr 2 = 0x00; read addr 4 = 0xFF.
- Tick=0 with WrEn addr 1 = 0x42 -> addr 1 unchanged, RdValid*=0. Repeat with Tick=1 -> 0x42 stored.
- NrOfRegs=6: write addr 7 and read addr 6 -> no state change, RdData=0, RdValid=1, AddrErr=1 until Reset. With cs=1, RdData0/RdData1=0 while RdValid is unaffected.
- Reg0Zero=1: write 0xFF to addr 0 -> read returns 0x00. Assert Reset on the same edge as a write to addr 1 = 0x99 -> addr 1 = 0x00 afterwards.
